// File: rtl/alu_exec_ctrl.sv
// rtl/alu_exec_ctrl.sv - execute-stage ALU with ALUop/funct decode and iterative mult/div into HI/LO
module alu_exec_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               ALUop,
  input  logic [5:0]               funct,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  input  logic [WIDTH-1:0]         operand_a,
  input  logic [WIDTH-1:0]         operand_b,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         result,
  output logic                     zero,
  output logic                     overflow
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

  state_e             state_q;
  logic [SHW:0]       cnt_q;
  logic               is_div_q, prod_neg_q, a_neg_q, b_zero_q;
  logic [WIDTH-1:0]   a_q, mcand_q, hi_q, lo_q;
  // mult: {accumulator, multiplier}; div: {remainder, dividend/quotient}
  logic [2*WIDTH-1:0] prod_q;
  logic               out_valid_q, zero_q, overflow_q;
  logic [WIDTH-1:0]   result_q;

  logic [WIDTH-1:0]   sum, diff, alu_res;
  logic               add_ovf, sub_ovf, alu_ovf, start_mul, start_div, sgn;
  logic [WIDTH-1:0]   mag_a, mag_b;

  assign sum     = operand_a + operand_b;
  assign diff    = operand_a - operand_b;
  assign add_ovf = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) && (sum[WIDTH-1] != operand_a[WIDTH-1]);
  assign sub_ovf = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) && (diff[WIDTH-1] != operand_a[WIDTH-1]);

  always_comb begin
    alu_res   = sum;
    alu_ovf   = 1'b0;
    start_mul = 1'b0;
    start_div = 1'b0;
    sgn       = 1'b0;
    case (ALUop)
      3'b000: alu_ovf = add_ovf;
      3'b001: begin alu_res = diff; alu_ovf = sub_ovf; end
      3'b011: alu_res = operand_a | operand_b;
      3'b100: alu_res = operand_a & operand_b;
      3'b010: begin
        case (funct)
          6'b100000: alu_ovf = add_ovf;
          6'b100010: begin alu_res = diff; alu_ovf = sub_ovf; end
          6'b100011: alu_res = diff;
          6'b100100: alu_res = operand_a & operand_b;
          6'b100101: alu_res = operand_a | operand_b;
          6'b100110: alu_res = operand_a ^ operand_b;
          6'b100111: alu_res = ~(operand_a | operand_b);
          6'b101010: alu_res = {{(WIDTH-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
          6'b101011: alu_res = {{(WIDTH-1){1'b0}}, operand_a < operand_b};
          6'b000000: alu_res = operand_b << shamt;
          6'b000010: alu_res = operand_b >> shamt;
          6'b000011: alu_res = $unsigned($signed(operand_b) >>> shamt);
          6'b010000: alu_res = hi_q;
          6'b010010: alu_res = lo_q;
          6'b011000: begin start_mul = 1'b1; sgn = 1'b1; end
          6'b011001: start_mul = 1'b1;
          6'b011010: begin start_div = 1'b1; sgn = 1'b1; end
          6'b011011: start_div = 1'b1;
          default: alu_res = sum;
        endcase
      end
      default: alu_res = sum;
    endcase
  end

  assign mag_a = (sgn && operand_a[WIDTH-1]) ? (~operand_a + 1'b1) : operand_a;
  assign mag_b = (sgn && operand_b[WIDTH-1]) ? (~operand_b + 1'b1) : operand_b;

  logic [WIDTH:0]     mul_sum, div_shift, div_trial;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, fix_hi, fix_lo;

  assign mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign mul_next  = {mul_sum, prod_q[WIDTH-1:1]};
  assign div_shift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, mcand_q};
  assign div_next  = div_trial[WIDTH] ? {div_shift[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};

  // Magnitude results get their signs back here; divide-by-zero bypasses the engine result
  assign prod_fix = prod_neg_q ? ('0 - prod_q) : prod_q;
  assign quo_fix  = prod_neg_q ? ('0 - prod_q[WIDTH-1:0]) : prod_q[WIDTH-1:0];
  assign rem_fix  = a_neg_q ? ('0 - prod_q[2*WIDTH-1:WIDTH]) : prod_q[2*WIDTH-1:WIDTH];

  always_comb begin
    fix_hi = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo = prod_fix[WIDTH-1:0];
    if (is_div_q) begin
      fix_hi = b_zero_q ? a_q : rem_fix;
      fix_lo = b_zero_q ? '1 : quo_fix;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      is_div_q    <= 1'b0;
      prod_neg_q  <= 1'b0;
      a_neg_q     <= 1'b0;
      b_zero_q    <= 1'b0;
      a_q         <= '0;
      mcand_q     <= '0;
      prod_q      <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            if (start_mul || start_div) begin
              state_q    <= start_mul ? S_MUL : S_DIV;
              cnt_q      <= (SHW+1)'(WIDTH);
              is_div_q   <= start_div;
              prod_neg_q <= sgn && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
              a_neg_q    <= sgn && operand_a[WIDTH-1];
              b_zero_q   <= (operand_b == '0);
              a_q        <= operand_a;
              mcand_q    <= start_mul ? mag_a : mag_b;
              prod_q     <= {{WIDTH{1'b0}}, start_mul ? mag_b : mag_a};
            end else begin
              out_valid_q <= 1'b1;
              result_q    <= alu_res;
              zero_q      <= (alu_res == '0);
              overflow_q  <= alu_ovf;
            end
          end
        end
        S_MUL, S_DIV: begin
          prod_q <= (state_q == S_MUL) ? mul_next : div_next;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == (SHW+1)'(1)) state_q <= S_FIX;
        end
        default: begin
          hi_q        <= fix_hi;
          lo_q        <= fix_lo;
          out_valid_q <= 1'b1;
          result_q    <= fix_lo;
          zero_q      <= (fix_lo == '0);
          overflow_q  <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign overflow  = overflow_q;
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb/tb_alu_exec_ctrl.sv - directed self-checking bench for alu_exec_ctrl
module tb_alu_exec_ctrl;
  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready;
  logic [2:0]  ALUop;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] operand_a, operand_b, result;
  logic        out_valid, zero, overflow;
  int          checks = 0;
  int          errors = 0;

  alu_exec_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ALUop(ALUop), .funct(funct), .shamt(shamt),
    .operand_a(operand_a), .operand_b(operand_b),
    .out_valid(out_valid), .result(result), .zero(zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [5:0] fn, input logic [4:0] sh,
                       input logic [31:0] a, input logic [31:0] b);
    ALUop = op; funct = fn; shamt = sh; operand_a = a; operand_b = b; in_valid = 1'b1;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [5:0] fn, input logic [4:0] sh,
                       input logic [31:0] a, input logic [31:0] b);
    drive(op, fn, sh, a, b);
    tick();
    in_valid = 1'b0;
  endtask

  // Issue a mult/div and wait for its completion pulse; returns cycles from acceptance
  task automatic long_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                         output int cyc, output int lows);
    drive(3'b010, fn, 5'd0, a, b);
    tick();
    cyc = 0; lows = 0;
    if (!in_ready) lows++;
    while (!out_valid && cyc < 100) begin
      tick();
      cyc++;
      if (!in_ready) lows++;
    end
    in_valid = 1'b0;
  endtask

  int cyc, lows, pulses;

  initial begin
    reset = 1'b1; in_valid = 1'b0;
    ALUop = '0; funct = '0; shamt = '0; operand_a = '0; operand_b = '0;
    tick(); tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 0);
    check("rst_overflow", overflow, 0);
    reset = 1'b0;

    drive(3'b010, 6'b100000, 0, 32'h7FFFFFFF, 32'h1);
    tick();
    check("add_valid", out_valid, 1);
    check("add_res", result, 32'h80000000);
    check("add_ovf", overflow, 1);
    drive(3'b010, 6'b100001, 0, 32'h7FFFFFFF, 32'h1);
    tick();
    check("addu_valid", out_valid, 1);
    check("addu_res", result, 32'h80000000);
    check("addu_ovf", overflow, 0);
    drive(3'b010, 6'b100011, 0, 32'd5, 32'd5);
    tick();
    in_valid = 1'b0;
    check("subu_valid", out_valid, 1);
    check("subu_res", result, 0);
    check("subu_zero", zero, 1);
    tick();
    check("idle_valid", out_valid, 0);

    do_op(3'b001, 6'b0, 0, 32'h80000000, 32'h1);
    check("aluop_sub_res", result, 32'h7FFFFFFF);
    check("aluop_sub_ovf", overflow, 1);
    do_op(3'b011, 6'b0, 0, 32'hF0F00000, 32'h0000F0F0);
    check("aluop_or", result, 32'hF0F0F0F0);
    do_op(3'b010, 6'b000000, 5'd4, 32'h0, 32'h80000010);
    check("sll", result, 32'h00000100);
    do_op(3'b010, 6'b000010, 5'd4, 32'h0, 32'h80000010);
    check("srl", result, 32'h08000001);
    do_op(3'b010, 6'b000011, 5'd4, 32'h0, 32'h80000010);
    check("sra", result, 32'hF8000001);
    do_op(3'b010, 6'b101010, 0, 32'hFFFFFFFF, 32'h1);
    check("slt", result, 1);
    do_op(3'b010, 6'b101011, 0, 32'hFFFFFFFF, 32'h1);
    check("sltu", result, 0);
    check("sltu_zero", zero, 1);

    long_op(6'b011000, 32'hFFFFFFFD, 32'd7, cyc, lows);
    check("mult_latency", cyc, 33);
    check("mult_ready_low", lows, 33);
    check("mult_result", result, 32'hFFFFFFEB);
    check("mult_ovf", overflow, 0);
    tick();
    check("mult_no_reissue", out_valid, 0);
    check("mult_ready_back", in_ready, 1);
    do_op(3'b010, 6'b010000, 0, 0, 0);
    check("mfhi_mult", result, 32'hFFFFFFFF);
    do_op(3'b010, 6'b010010, 0, 0, 0);
    check("mflo_mult", result, 32'hFFFFFFEB);

    long_op(6'b011010, 32'hFFFFFFF9, 32'd2, cyc, lows);
    check("div_result", result, 32'hFFFFFFFD);
    do_op(3'b010, 6'b010000, 0, 0, 0);
    check("mfhi_div", result, 32'hFFFFFFFF);

    long_op(6'b011011, 32'd9, 32'd0, cyc, lows);
    check("divu0_result", result, 32'hFFFFFFFF);
    do_op(3'b010, 6'b010000, 0, 0, 0);
    check("mfhi_divu0", result, 32'd9);

    long_op(6'b011010, 32'h80000000, 32'hFFFFFFFF, cyc, lows);
    check("div_minneg_lo", result, 32'h80000000);
    do_op(3'b010, 6'b010000, 0, 0, 0);
    check("div_minneg_hi", result, 0);

    drive(3'b010, 6'b011001, 0, 32'd1234, 32'd5678);
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    pulses = 0;
    repeat (40) begin
      tick();
      if (out_valid) pulses++;
    end
    check("abort_no_pulse", pulses, 0);
    do_op(3'b010, 6'b010000, 0, 0, 0);
    check("abort_hi", result, 0);
    do_op(3'b010, 6'b010010, 0, 0, 0);
    check("abort_lo", result, 0);
    do_op(3'b000, 6'b0, 0, 32'd2, 32'd3);
    check("post_add_valid", out_valid, 1);
    check("post_add_res", result, 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_exec_ctrl.md
# alu_exec_ctrl

Parametrised execute-stage unit that combines ALU operation decoding (ALUop/funct) with a registered ALU datapath and an iterative multiply/divide engine writing HI/LO. It sits between the register-read stage and writeback, replacing the purely combinational ALU-control decode with a valid/ready execute slot. Single-cycle operations complete with one-cycle latency. mult/div stall the issue side through `in_ready` for WIDTH+1 cycles.

## Interface
- `WIDTH`, 32: datapath width; must be ≥ 8 and a power of two. Localparam `SHW = $clog2(WIDTH)`.
- `clk` input 1: single clock, all state updates on rising edge.
- `reset` input 1: synchronous, active-high.
- `in_valid` input 1: operation present on the input ports.
- `in_ready` output 1: unit can accept; operation accepted on an edge where `in_valid && in_ready`.
- `ALUop` input 3: 000 add, 001 sub, 010 R-type (use `funct`), 011 or, 100 and, others add.
- `funct` input 6: R-type function code.
- `shamt` input SHW: shift amount.
- `operand_a`, `operand_b` input WIDTH: rs/rt (or rs/imm) values.
- `out_valid` output 1: one-cycle pulse, `result` and flags valid.
- `result` output WIDTH: registered result.
- `zero` output 1: `result == 0`, registered with `result`.
- `overflow` output 1: signed overflow, add/sub only.

## Operation
- funct decode (ALUop=010):
  - 100000 add, 100001 addu, 100010 sub, 100011 subu.
  - 100100 and, 100101 or, 100110 xor, 100111 nor.
  - 101010 slt (signed), 101011 sltu.
  - 000000 sll, 000010 srl, 000011 sra, all by `shamt`.
  - 010000 mfhi, 010010 mflo.
  - 011000 mult, 011001 multu, 011010 div, 011011 divu.
  - Any other funct executes as addu.
- Arithmetic is modulo 2^WIDTH. slt/sltu return zero-extended 0/1.
- `overflow` is set only for add/sub (ALUop 000, 001, funct add/sub) on signed overflow. It is 0 for addu/subu and all other ops.
- The ALU does not trap: the result is still written when `overflow` is set.
- HI/LO: internal WIDTH-bit registers, written only by mult/div completion.
  - mult/multu: {HI,LO} = 2·WIDTH-bit product, signed or unsigned.
  - div/divu: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - Divide by zero: LO = all ones, HI = operand_a. No exception.
  - Signed most-negative ÷ −1: LO = operand_a, HI = 0.
- Iterative engine: shift-add multiply and restoring divide, one bit per cycle, operating on magnitudes; sign fix-up happens in the final state.
- States:
  - IDLE: `in_ready`=1. Accepting a single-cycle op stays in IDLE. Accepting mult/multu moves to MUL; div/divu moves to DIV. In both cases operands and signedness are latched and the counter is set to WIDTH.
  - MUL/DIV: `in_ready`=0. One iteration per cycle, counter decrements. When the counter reaches 1, the next state is FIX.
  - FIX: `in_ready`=0. Apply signs, write HI/LO. Next state is IDLE.
- mult/div completion: `out_valid` pulses with `result` = new LO, `zero` computed on it, `overflow`=0.
- `in_valid` while `in_ready`=0 is ignored. The issuer must hold the operation.

## Timing
- Reset values:
  - State is IDLE; `in_ready`=1.
  - `out_valid`, `result`, `zero`, `overflow`, HI and LO are all 0.
  - `zero` resets to 0 even though `result`=0.
- Single-cycle op accepted at edge N: `result` and `out_valid`=1 after edge N; `out_valid` is back to 0 after edge N+1 unless another op is accepted. Back-to-back issue gives one result per cycle.
- mult/div accepted at edge N:
  - Iterations run on edges N+1..N+WIDTH.
  - FIX completes on edge N+WIDTH+1: HI/LO are updated, `out_valid`=1, and `in_ready`=1 from then on.
  - Total latency is WIDTH+1 cycles; `in_ready` is low for WIDTH+1 cycles.
- mfhi/mflo accepted on the edge right after FIX returns the new HI/LO (no forwarding hazard).
- `reset` asserted in any state: at that edge, return to the reset values above and abort any in-flight mult/div. HI/LO are not updated with partial results.
- `out_valid` never pulses for an aborted op.

## Test plan
- WIDTH=32, back-to-back issue:
  - add 0x7FFFFFFF+1 → 0x80000000, `overflow`=1.
  - addu of the same operands → 0x80000000, `overflow`=0.
  - subu 5−5 → 0, `zero`=1.
  - All three results arrive on consecutive cycles.
- Shifts with `operand_b`=0x80000010 and `shamt`=4 (shifts act on `operand_b`):
  - sll → 0x00000100.
  - srl → 0x08000001.
  - sra → 0xF8000001.
- slt vs sltu with a=0xFFFFFFFF, b=1: slt → 1, sltu → 0.
- mult a=−3, b=7, then mfhi and mflo:
  - `out_valid` 33 cycles after acceptance; `in_ready` low for 33 cycles.
  - mfhi → 0xFFFFFFFF, mflo → 0xFFFFFFEB.
  - `in_valid` held high during the stall is not accepted twice.
- div a=−7, b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu a=9, b=0 → LO=0xFFFFFFFF, HI=9.
- Reset asserted 10 cycles into a multu:
  - `in_ready`=1, `out_valid`=0, HI=LO=0 after the edge.
  - No `out_valid` pulse appears later.
  - A following add issues normally.
